// File: rtl/piarb_wr_arb_if.sv
// piarb_wr_arb_if: ingress chunk, free-buffer and buffer-write signals of the write arbiter
interface piarb_wr_arb_if #(
    parameter int NUM_PORTS  = 4,
    parameter int ID_NBITS   = 4,
    parameter int BPTR_NBITS = 8,
    parameter int DATA_NBITS = 32
);
    logic [NUM_PORTS-1:0]            in_valid;
    logic [NUM_PORTS-1:0]            in_sop;
    logic [NUM_PORTS-1:0]            in_eop;
    logic [NUM_PORTS*DATA_NBITS-1:0] in_data;
    logic [NUM_PORTS-1:0]            in_ready;
    logic                            free_buf_req;
    logic                            free_buf_valid;
    logic [BPTR_NBITS-1:0]           free_buf_ptr;
    logic                            free_buf_available;
    logic                            write_data_valid;
    logic [BPTR_NBITS-1:0]           write_buf_ptr;
    logic [DATA_NBITS-1:0]           write_data;
    logic                            write_sop;
    logic [ID_NBITS-1:0]             write_port_id;
    logic                            err_proto;
    logic                            err_unexp_buf;

    modport master (
        input  in_valid, in_sop, in_eop, in_data, free_buf_valid, free_buf_ptr, free_buf_available,
        output in_ready, free_buf_req, write_data_valid, write_buf_ptr, write_data, write_sop,
               write_port_id, err_proto, err_unexp_buf
    );

    modport slave (
        output in_valid, in_sop, in_eop, in_data, free_buf_valid, free_buf_ptr, free_buf_available,
        input  in_ready, free_buf_req, write_data_valid, write_buf_ptr, write_data, write_sop,
               write_port_id, err_proto, err_unexp_buf
    );
endinterface

// File: rtl/piarb_wr_arb.sv
// piarb_wr_arb: packet-granular round-robin write arbiter with one-deep free-buffer prefetch
module piarb_wr_arb #(
    parameter int NUM_PORTS  = 4,
    parameter int ID_NBITS   = 4,
    parameter int BPTR_NBITS = 8,
    parameter int DATA_NBITS = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    piarb_wr_arb_if.master   bus
);
    localparam int IDX = $clog2(NUM_PORTS);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                r_state, w_next_state;
    logic [IDX-1:0]        r_last_grant, r_owner;
    logic [IDX-1:0]        w_win, w_low, w_port, w_idx;
    logic                  w_has_sop, w_accept, w_discard, w_sop_err, w_req;
    logic [NUM_PORTS-1:0]  w_sop_cand, w_ready;
    logic                  r_pf_valid, r_req_pending;
    logic [BPTR_NBITS-1:0] r_pf_ptr, r_wptr;
    logic                  r_wvalid, r_wsop, r_err_proto, r_err_unexp;
    logic [DATA_NBITS-1:0] r_wdata;
    logic [ID_NBITS-1:0]   r_wid;

    assign w_sop_cand = bus.in_valid & bus.in_sop;

    // Round-robin winner among sop candidates; lowest valid port for stray mid-packet chunks
    always_comb begin
        w_win     = '0;
        w_has_sop = 1'b0;
        w_low     = '0;
        w_idx     = '0;
        for (int i = NUM_PORTS; i >= 1; i--) begin
            w_idx = r_last_grant + IDX'(i);
            if (w_sop_cand[w_idx]) begin
                w_win     = w_idx;
                w_has_sop = 1'b1;
            end
        end
        for (int i = NUM_PORTS - 1; i >= 0; i--)
            if (bus.in_valid[i]) w_low = IDX'(i);
    end

    // Acceptance, per-port ready and next-state decision
    always_comb begin
        w_port       = r_owner;
        w_accept     = 1'b0;
        w_discard    = 1'b0;
        w_sop_err    = 1'b0;
        w_ready      = '0;
        w_next_state = r_state;
        if (r_state == IDLE) begin
            if (w_has_sop) begin
                w_port   = w_win;
                w_accept = r_pf_valid;
            end else begin
                w_port    = w_low;
                w_discard = |bus.in_valid;
            end
            if (w_accept && !bus.in_eop[w_port]) w_next_state = BUSY;
        end else begin
            w_accept  = bus.in_valid[r_owner] & r_pf_valid;
            w_sop_err = w_accept & bus.in_sop[r_owner];
            if (w_accept && bus.in_eop[r_owner]) w_next_state = IDLE;
        end
        w_ready[w_port] = w_accept | w_discard;
    end

    // Ready and buffer request are held low while reset is asserted
    assign w_req        = rst_n & ~r_pf_valid & ~r_req_pending & bus.free_buf_available;
    assign bus.in_ready = rst_n ? w_ready : '0;

    // Prefetch bookkeeping, grant state, registered write port and sticky errors
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_last_grant  <= IDX'(NUM_PORTS - 1);
            r_owner       <= '0;
            r_pf_valid    <= 1'b0;
            r_pf_ptr      <= '0;
            r_req_pending <= 1'b0;
            r_wvalid      <= 1'b0;
            r_wptr        <= '0;
            r_wdata       <= '0;
            r_wsop        <= 1'b0;
            r_wid         <= '0;
            r_err_proto   <= 1'b0;
            r_err_unexp   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_req) r_req_pending <= 1'b1;
            else if (bus.free_buf_valid) r_req_pending <= 1'b0;
            if (w_accept) r_pf_valid <= 1'b0;
            else if (bus.free_buf_valid && r_req_pending) begin
                r_pf_valid <= 1'b1;
                r_pf_ptr   <= bus.free_buf_ptr;
            end
            if (w_accept && r_state == IDLE) begin
                r_last_grant <= w_port;
                r_owner      <= w_port;
            end
            r_wvalid <= w_accept;
            if (w_accept) begin
                r_wptr  <= r_pf_ptr;
                r_wdata <= bus.in_data[w_port*DATA_NBITS +: DATA_NBITS];
                r_wsop  <= (r_state == IDLE);
                r_wid   <= ID_NBITS'(w_port);
            end
            r_err_proto <= r_err_proto | w_discard | w_sop_err;
            r_err_unexp <= r_err_unexp | (bus.free_buf_valid & ~r_req_pending);
        end
    end

    assign bus.free_buf_req     = w_req;
    assign bus.write_data_valid = r_wvalid;
    assign bus.write_buf_ptr    = r_wptr;
    assign bus.write_data       = r_wdata;
    assign bus.write_sop        = r_wsop;
    assign bus.write_port_id    = r_wid;
    assign bus.err_proto        = r_err_proto;
    assign bus.err_unexp_buf    = r_err_unexp;
endmodule

// File: tb/tb_piarb_wr_arb.sv
// tb_piarb_wr_arb: directed self-checking bench for the round-robin write arbiter
module tb_piarb_wr_arb;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   reqs = 0;
    logic [7:0] nptr = 8'd7;
    logic [7:0] last_ptr = 8'd0;
    logic src_en = 1'b0;
    int   plen[4], pcnt[4], pleft[4];

    typedef struct {
        int          port;
        logic        sop;
        logic [31:0] data;
    } wr_t;
    wr_t wq[$];

    piarb_wr_arb_if #(.NUM_PORTS(4), .ID_NBITS(4), .BPTR_NBITS(8), .DATA_NBITS(32)) bus();

    piarb_wr_arb #(.NUM_PORTS(4), .ID_NBITS(4), .BPTR_NBITS(8), .DATA_NBITS(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_ports();
        for (int p = 0; p < 4; p++) begin
            bus.in_valid[p] = pleft[p] > 0;
            bus.in_sop[p]   = pcnt[p] == 0;
            bus.in_eop[p]   = pcnt[p] == plen[p] - 1;
            bus.in_data[p*32 +: 32] = 32'(p * 256 + pleft[p] * 16 + pcnt[p]);
        end
    endtask

    // One clock: buffer manager answers a request one cycle later; writes are logged; sources advance
    task automatic tick();
        logic       req;
        logic [3:0] rdy;
        #1;
        req = bus.free_buf_req;
        rdy = bus.in_ready;
        if (req) reqs++;
        @(posedge clk);
        #1;
        bus.free_buf_valid = req;
        if (req) begin
            bus.free_buf_ptr = nptr;
            last_ptr = nptr;
            nptr++;
        end
        if (bus.write_data_valid)
            wq.push_back('{int'(bus.write_port_id), bus.write_sop, bus.write_data});
        if (src_en) begin
            for (int p = 0; p < 4; p++)
                if (rdy[p] && bus.in_valid[p]) begin
                    pcnt[p]++;
                    if (pcnt[p] == plen[p]) begin
                        pcnt[p] = 0;
                        pleft[p]--;
                    end
                end
            drive_ports();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        src_en = 1'b0;
        bus.in_valid = '0;
        bus.in_sop = '0;
        bus.in_eop = '0;
        bus.in_data = '0;
        bus.free_buf_valid = 1'b0;
        bus.free_buf_available = 1'b0;
        for (int p = 0; p < 4; p++) begin
            plen[p] = 1;
            pcnt[p] = 0;
            pleft[p] = 0;
        end
        tick();
        tick();
    endtask

    initial begin
        bus.free_buf_ptr = '0;
        do_reset();
        chk("rst_in_ready", bus.in_ready, 4'b0000);
        chk("rst_req", bus.free_buf_req, 1'b0);
        chk("rst_wdv", bus.write_data_valid, 1'b0);
        chk("rst_err_proto", bus.err_proto, 1'b0);
        chk("rst_err_unexp", bus.err_unexp_buf, 1'b0);
        chk("rst_last_grant", dut.r_last_grant, 2'd3);
        chk("rst_state", dut.r_state, 1'b0);

        // single-chunk packet from port 2, buffer pointer 7
        rst_n = 1'b1;
        reqs = 0;
        bus.free_buf_available = 1'b1;
        bus.in_valid = 4'b0100;
        bus.in_sop = 4'b0100;
        bus.in_eop = 4'b0100;
        bus.in_data[2*32 +: 32] = 32'hA5;
        #1;
        chk("t1_req_pulse", bus.free_buf_req, 1'b1);
        chk("t1_no_ready_c0", bus.in_ready, 4'b0000);
        tick();
        chk("t1_req_once", bus.free_buf_req, 1'b0);
        chk("t1_no_ready_c1", bus.in_ready, 4'b0000);
        tick();
        chk("t1_ready", bus.in_ready, 4'b0100);
        tick();
        bus.in_valid = '0;
        chk("t1_wdv", bus.write_data_valid, 1'b1);
        chk("t1_ptr", bus.write_buf_ptr, 8'd7);
        chk("t1_data", bus.write_data, 32'hA5);
        chk("t1_sop", bus.write_sop, 1'b1);
        chk("t1_port", bus.write_port_id, 4'd2);
        chk("t1_state", dut.r_state, 1'b0);
        chk("t1_last_grant", dut.r_last_grant, 2'd2);
        tick();
        chk("t1_wdv_pulse", bus.write_data_valid, 1'b0);

        // ports 0 and 1 each send a 3-chunk packet; no interleaving
        do_reset();
        rst_n = 1'b1;
        reqs = 0;
        wq.delete();
        plen[0] = 3; pleft[0] = 1;
        plen[1] = 3; pleft[1] = 1;
        src_en = 1'b1;
        bus.free_buf_available = 1'b1;
        drive_ports();
        for (int k = 0; k < 60 && wq.size() < 6; k++) tick();
        chk("t2_writes", wq.size(), 6);
        for (int i = 0; i < 6 && i < wq.size(); i++) begin
            chk($sformatf("t2_port%0d", i), wq[i].port, i / 3);
            chk($sformatf("t2_sop%0d", i), wq[i].sop, (i % 3) == 0);
            chk($sformatf("t2_data%0d", i), wq[i].data, 32'((i / 3) * 256 + 16 + i % 3));
        end
        chk("t2_req_pulses", reqs, 6);

        // all ports stream single-chunk packets: strict rotation
        do_reset();
        rst_n = 1'b1;
        wq.delete();
        for (int p = 0; p < 4; p++) pleft[p] = 3;
        src_en = 1'b1;
        bus.free_buf_available = 1'b1;
        drive_ports();
        for (int k = 0; k < 100 && wq.size() < 12; k++) tick();
        chk("t3_writes", wq.size(), 12);
        for (int i = 0; i < 12 && i < wq.size(); i++) begin
            chk($sformatf("t3_port%0d", i), wq[i].port, i % 4);
            chk($sformatf("t3_data%0d", i), wq[i].data, 32'((i % 4) * 256 + (3 - i / 4) * 16));
        end

        // free list empty for 20 cycles while port 3 waits
        do_reset();
        rst_n = 1'b1;
        bus.in_valid = 4'b1000;
        bus.in_sop = 4'b1000;
        bus.in_eop = 4'b1000;
        bus.in_data[3*32 +: 32] = 32'h33;
        begin
            logic seen_req, seen_rdy;
            seen_req = 1'b0;
            seen_rdy = 1'b0;
            for (int k = 0; k < 20; k++) begin
                tick();
                seen_req |= bus.free_buf_req;
                seen_rdy |= |bus.in_ready;
            end
            chk("t4_no_req", seen_req, 1'b0);
            chk("t4_no_ready", seen_rdy, 1'b0);
        end
        bus.free_buf_available = 1'b1;
        #1;
        chk("t4_req_rise", bus.free_buf_req, 1'b1);
        tick();
        chk("t4_wdv_c1", bus.write_data_valid, 1'b0);
        tick();
        chk("t4_ready_c2", bus.in_ready, 4'b1000);
        chk("t4_wdv_c2", bus.write_data_valid, 1'b0);
        tick();
        bus.free_buf_available = 1'b0;
        bus.in_valid = '0;
        chk("t4_wdv_c3", bus.write_data_valid, 1'b1);
        chk("t4_port", bus.write_port_id, 4'd3);
        chk("t4_data", bus.write_data, 32'h33);
        chk("t4_ptr", bus.write_buf_ptr, last_ptr);

        // unsolicited buffer return, then stray mid-packet chunk in IDLE
        bus.free_buf_valid = 1'b1;
        bus.free_buf_ptr = 8'h55;
        tick();
        chk("t5_err_unexp", bus.err_unexp_buf, 1'b1);
        chk("t5_pf_valid", dut.r_pf_valid, 1'b0);
        chk("t5_pf_ptr", dut.r_pf_ptr, last_ptr);
        chk("t5_err_proto_clear", bus.err_proto, 1'b0);
        bus.in_valid = 4'b0010;
        bus.in_sop = 4'b0000;
        bus.in_eop = 4'b0000;
        #1;
        chk("t5_discard_ready", bus.in_ready, 4'b0010);
        tick();
        bus.in_valid = '0;
        chk("t5_no_write", bus.write_data_valid, 1'b0);
        chk("t5_err_proto", bus.err_proto, 1'b1);
        chk("t5_state", dut.r_state, 1'b0);
        chk("t5_err_unexp_sticky", bus.err_unexp_buf, 1'b1);

        // reset in the middle of a packet
        plen[0] = 3; pcnt[0] = 0; pleft[0] = 1;
        src_en = 1'b1;
        bus.free_buf_available = 1'b1;
        drive_ports();
        for (int k = 0; k < 20 && dut.r_state !== 1'b1; k++) tick();
        chk("t6_busy", dut.r_state, 1'b1);
        src_en = 1'b0;
        rst_n = 1'b0;
        tick();
        chk("t6_state", dut.r_state, 1'b0);
        chk("t6_ready", bus.in_ready, 4'b0000);
        chk("t6_wdv", bus.write_data_valid, 1'b0);
        chk("t6_err_proto", bus.err_proto, 1'b0);
        chk("t6_err_unexp", bus.err_unexp_buf, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
